// File: rtl/ccff_loader_if.sv
// ---------------------------------------------------------------------------
// ccff_loader_if
// Byte streams between a bitstream source/sink and the configuration-chain
// loader.
//   in_data/in_valid/in_ready    : configuration bytes towards the loader
//   out_data/out_valid/out_ready : readback bytes from the loader
// Modports:
//   master : the environment side (drives in_*, consumes out_*)
//   slave  : the loader side
// ---------------------------------------------------------------------------
interface ccff_loader_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/ccff_loader.sv
// ---------------------------------------------------------------------------
// ccff_loader
// Drives the head of the fabric configuration chain. LOAD serialises
// incoming bytes MSB-first into the chain, one bit per chain_en cycle.
// READ circulates ccff_tail back into ccff_head so that the configuration
// survives, and repacks the recovered bits into readback bytes.
//
// Ports:
//   prog_clk    configuration clock (rising edge)
//   reset       asynchronous, active-low
//   start_load  pulse, starts a load (accepted in IDLE/DONE/ERR)
//   start_read  pulse, starts a readback (start_load wins)
//   abort       forces ERR from LOAD/READ
//   bus         byte streams (ccff_loader_if.slave)
//   ccff_head   serial bit into the chain
//   ccff_tail   serial bit out of the chain
//   chain_en    chain shifts on the edge where this is high
//   busy        high in LOAD or READ
//   done        sticky completion flag
//   err         sticky abort flag
// ---------------------------------------------------------------------------
module ccff_loader #(
    parameter int CHAIN_LEN = 64,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic            prog_clk,
    input  logic            reset,
    input  logic            start_load,
    input  logic            start_read,
    input  logic            abort,
    ccff_loader_if.slave    bus,
    output logic            ccff_head,
    input  logic            ccff_tail,
    output logic            chain_en,
    output logic            busy,
    output logic            done,
    output logic            err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_READ,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN);

    state_t           state_q, state_nxt;
    logic [7:0]       shreg_q, shreg_nxt;     // bits of the current load byte still to send
    logic [2:0]       rem_q, rem_nxt;         // how many bits remain in shreg_q
    logic [CNT_W-1:0] bitcnt_q, bitcnt_nxt;   // bits issued to the chain so far
    logic             head_q, head_nxt;
    logic             chain_en_q, chain_en_nxt;
    logic [7:0]       creg_q, creg_nxt;       // readback collection register
    logic [3:0]       ccnt_q, ccnt_nxt;       // bits collected into creg_q
    logic             cpend_q, cpend_nxt;     // creg_q holds a finished byte awaiting out_data
    logic [7:0]       odata_q, odata_nxt;
    logic             ovalid_q, ovalid_nxt;
    logic             done_q, done_nxt;
    logic             err_q, err_nxt;

    logic             chain_full;
    logic             in_ready_c;
    logic             in_fire;
    logic             out_fire;
    logic             slot_free;
    logic             blocked;
    logic [7:0]       captured;

    always_ff @(posedge prog_clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            shreg_q    <= '0;
            rem_q      <= '0;
            bitcnt_q   <= '0;
            head_q     <= 1'b0;
            chain_en_q <= 1'b0;
            creg_q     <= '0;
            ccnt_q     <= '0;
            cpend_q    <= 1'b0;
            odata_q    <= '0;
            ovalid_q   <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            shreg_q    <= shreg_nxt;
            rem_q      <= rem_nxt;
            bitcnt_q   <= bitcnt_nxt;
            head_q     <= head_nxt;
            chain_en_q <= chain_en_nxt;
            creg_q     <= creg_nxt;
            ccnt_q     <= ccnt_nxt;
            cpend_q    <= cpend_nxt;
            odata_q    <= odata_nxt;
            ovalid_q   <= ovalid_nxt;
            done_q     <= done_nxt;
            err_q      <= err_nxt;
        end
    end

    // Once the last bit has been issued no further byte may be taken, and an
    // abort in the same cycle must not consume the offered byte.
    assign chain_full = (bitcnt_q == LAST);
    assign in_ready_c = (state_q == S_LOAD) && (rem_q == 3'd0) && !chain_full && !abort;
    assign in_fire    = in_ready_c && bus.in_valid;
    assign out_fire   = ovalid_q && bus.out_ready;
    assign slot_free  = !ovalid_q || bus.out_ready;

    always_comb begin
        state_nxt    = state_q;
        shreg_nxt    = shreg_q;
        rem_nxt      = rem_q;
        bitcnt_nxt   = bitcnt_q;
        head_nxt     = 1'b0;
        chain_en_nxt = 1'b0;
        creg_nxt     = creg_q;
        ccnt_nxt     = ccnt_q;
        cpend_nxt    = cpend_q;
        odata_nxt    = odata_q;
        ovalid_nxt   = ovalid_q && !bus.out_ready;
        done_nxt     = done_q;
        err_nxt      = err_q;
        blocked      = 1'b0;
        // Tail bit placed MSB-first at the next free position; unfilled LSBs
        // stay zero, which pads a final partial byte.
        captured     = creg_q | ({7'd0, ccff_tail} << (3'd7 - ccnt_q[2:0]));

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start_load) begin
                    state_nxt  = S_LOAD;
                    done_nxt   = 1'b0;
                    err_nxt    = 1'b0;
                    bitcnt_nxt = '0;
                    rem_nxt    = '0;
                    shreg_nxt  = '0;
                end else if (start_read) begin
                    // First shift is issued right away, so bitcnt starts at one.
                    state_nxt    = S_READ;
                    done_nxt     = 1'b0;
                    err_nxt      = 1'b0;
                    bitcnt_nxt   = CNT_W'(1);
                    chain_en_nxt = 1'b1;
                    creg_nxt     = '0;
                    ccnt_nxt     = '0;
                    cpend_nxt    = 1'b0;
                    ovalid_nxt   = 1'b0;
                end
            end

            S_LOAD: begin
                if (abort) begin
                    state_nxt = S_ERR;
                    err_nxt   = 1'b1;
                    rem_nxt   = '0;
                    shreg_nxt = '0;
                end else if (chain_full) begin
                    // The final bit is on the chain this cycle; any LSBs left
                    // in shreg_q are surplus and dropped.
                    state_nxt = S_DONE;
                    done_nxt  = 1'b1;
                    rem_nxt   = '0;
                    shreg_nxt = '0;
                end else if (in_fire) begin
                    head_nxt     = bus.in_data[7];
                    chain_en_nxt = 1'b1;
                    shreg_nxt    = {bus.in_data[6:0], 1'b0};
                    rem_nxt      = 3'd7;
                    bitcnt_nxt   = bitcnt_q + CNT_W'(1);
                end else if (rem_q != 3'd0) begin
                    head_nxt     = shreg_q[7];
                    chain_en_nxt = 1'b1;
                    shreg_nxt    = {shreg_q[6:0], 1'b0};
                    rem_nxt      = rem_q - 3'd1;
                    bitcnt_nxt   = bitcnt_q + CNT_W'(1);
                end
            end

            S_READ: begin
                if (abort) begin
                    state_nxt  = S_ERR;
                    err_nxt    = 1'b1;
                    ovalid_nxt = 1'b0;
                    cpend_nxt  = 1'b0;
                    ccnt_nxt   = '0;
                    creg_nxt   = '0;
                end else begin
                    if (chain_en_q) begin
                        // A tail bit is captured at this edge.
                        if ((ccnt_q == 4'd7) || chain_full) begin
                            if (slot_free) begin
                                odata_nxt  = captured;
                                ovalid_nxt = 1'b1;
                                creg_nxt   = '0;
                                ccnt_nxt   = '0;
                            end else begin
                                // Previous byte still unaccepted: park this one
                                // and hold the chain until out_data frees up.
                                creg_nxt  = captured;
                                ccnt_nxt  = ccnt_q + 4'd1;
                                cpend_nxt = 1'b1;
                                blocked   = 1'b1;
                            end
                        end else begin
                            creg_nxt = captured;
                            ccnt_nxt = ccnt_q + 4'd1;
                        end
                    end else if (cpend_q) begin
                        if (slot_free) begin
                            odata_nxt  = creg_q;
                            ovalid_nxt = 1'b1;
                            creg_nxt   = '0;
                            ccnt_nxt   = '0;
                            cpend_nxt  = 1'b0;
                        end else begin
                            blocked = 1'b1;
                        end
                    end else if (chain_full && out_fire) begin
                        state_nxt = S_DONE;
                        done_nxt  = 1'b1;
                    end

                    if (!chain_full && !blocked) begin
                        chain_en_nxt = 1'b1;
                        bitcnt_nxt   = bitcnt_q + CNT_W'(1);
                    end
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // In READ the head must be a pure wire from the tail: a registered head
    // would add a stage to the loop and rotate the configuration by one.
    assign ccff_head     = ((state_q == S_READ) && chain_en_q) ? ccff_tail : head_q;
    assign chain_en      = chain_en_q;
    assign busy          = (state_q == S_LOAD) || (state_q == S_READ);
    assign done          = done_q;
    assign err           = err_q;
    assign bus.in_ready  = in_ready_c;
    assign bus.out_data  = odata_q;
    assign bus.out_valid = ovalid_q;

endmodule

// File: tb/tb_ccff_loader.sv
// ---------------------------------------------------------------------------
// tb_ccff_loader
// Directed bench for ccff_loader with CHAIN_LEN=12 and a 12-bit shift-register
// model of the configuration chain attached to ccff_head/ccff_tail.
// ---------------------------------------------------------------------------
module tb_ccff_loader;

    localparam int CHAIN_LEN = 12;

    logic prog_clk = 1'b0;
    logic reset;
    logic start_load;
    logic start_read;
    logic abort;
    logic ccff_head;
    logic ccff_tail;
    logic chain_en;
    logic busy;
    logic done;
    logic err;

    ccff_loader_if bus();

    ccff_loader #(.CHAIN_LEN(CHAIN_LEN)) dut (
        .prog_clk   (prog_clk),
        .reset      (reset),
        .start_load (start_load),
        .start_read (start_read),
        .abort      (abort),
        .bus        (bus),
        .ccff_head  (ccff_head),
        .ccff_tail  (ccff_tail),
        .chain_en   (chain_en),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 prog_clk = ~prog_clk;

    // Chain model: first bit shifted in ends at chain[11], nearest the tail.
    logic [CHAIN_LEN-1:0] chain = '0;
    assign ccff_tail = chain[CHAIN_LEN-1];
    always @(posedge prog_clk) begin
        if (chain_en) chain <= {chain[CHAIN_LEN-2:0], ccff_head};
    end

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    logic [63:0] hbits;
    int         hcnt;
    int         first_en;
    int         last_en;
    logic [7:0] obytes[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clr_log();
        hbits    = '0;
        hcnt     = 0;
        first_en = -1;
        last_en  = -1;
        obytes.delete();
    endtask

    // Observe mid-cycle, then advance to just after the next rising edge.
    task automatic tick();
        @(negedge prog_clk);
        if (chain_en) begin
            hbits = {hbits[62:0], ccff_head};
            hcnt++;
            if (first_en < 0) first_en = cyc;
            last_en = cyc;
        end
        if (bus.out_valid && bus.out_ready) obytes.push_back(bus.out_data);
        cyc++;
        @(posedge prog_clk);
        #1;
    endtask

    // Wait for in_ready, idle for 'gap' cycles, then hand over one byte.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        t = 0;
        bus.in_valid = 1'b0;
        while (!bus.in_ready && t < 40) begin
            tick();
            t++;
        end
        repeat (gap) tick();
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && t < 80) begin
            tick();
            t++;
        end
        check("hs_ready", bus.in_ready, 1'b1);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int t;
        t = 0;
        while (!done && t < 100) begin
            tick();
            t++;
        end
        check(tag, done, 1'b1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_head"},   ccff_head,     1'b0);
        check({tag, "_en"},     chain_en,      1'b0);
        check({tag, "_irdy"},   bus.in_ready,  1'b0);
        check({tag, "_ovld"},   bus.out_valid, 1'b0);
        check({tag, "_odata"},  bus.out_data,  8'h00);
        check({tag, "_busy"},   busy,          1'b0);
        check({tag, "_done"},   done,          1'b0);
        check({tag, "_err"},    err,           1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got running, expected finished");
        $fatal(1);
    end

    initial begin
        int         t;
        int         n0;
        logic       saw;
        logic [7:0] b0;
        logic [7:0] b1;

        reset         = 1'b1;
        start_load    = 1'b0;
        start_read    = 1'b0;
        abort         = 1'b0;
        bus.in_data   = 8'h00;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        clr_log();

        // Reset state
        #2 reset = 1'b0;
        #2;
        check_all_zero("rst");
        tick();
        tick();
        reset = 1'b1;
        tick();

        // Load 0xA5, 0x3C back to back; a third byte must be refused
        clr_log();
        start_load = 1'b1;
        tick();
        start_load = 1'b0;
        check("ld_busy", busy, 1'b1);
        check("ld_ready_first", bus.in_ready, 1'b1);
        send_byte(8'hA5, 0);
        send_byte(8'h3C, 0);
        bus.in_data  = 8'hFF;
        bus.in_valid = 1'b1;
        saw = 1'b0;
        t = 0;
        while (!done && t < 40) begin
            if (bus.in_ready) saw = 1'b1;
            tick();
            t++;
        end
        check("ld_done", done, 1'b1);
        check("ld_extra_ready_seen", saw, 1'b0);
        check("ld_ready_after", bus.in_ready, 1'b0);
        bus.in_valid = 1'b0;
        check("ld_bits", hbits[11:0], 12'hA53);
        check("ld_nbits", hcnt, 12);
        check("ld_span", last_en - first_en + 1, 12);
        check("ld_chain", chain, 12'hA53);
        check("ld_busy_end", busy, 1'b0);

        // Readback with the consumer always ready
        clr_log();
        bus.out_ready = 1'b1;
        start_read = 1'b1;
        tick();
        start_read = 1'b0;
        check("rd_first_en", chain_en, 1'b1);
        check("rd_done_clr", done, 1'b0);
        check("rd_busy", busy, 1'b1);
        wait_done("rd_done");
        b0 = (obytes.size() > 0) ? obytes[0] : 8'hEE;
        b1 = (obytes.size() > 1) ? obytes[1] : 8'hEE;
        check("rd_nbytes", obytes.size(), 2);
        check("rd_byte0", b0, 8'hA5);
        check("rd_byte1", b1, 8'h30);
        check("rd_chain", chain, 12'hA53);
        check("rd_nbits", hcnt, 12);
        check("rd_ovalid_end", bus.out_valid, 1'b0);

        // Readback with a 5-cycle consumer stall after the first byte
        clr_log();
        bus.out_ready = 1'b0;
        start_read = 1'b1;
        tick();
        start_read = 1'b0;
        t = 0;
        while (!bus.out_valid && t < 40) begin
            tick();
            t++;
        end
        check("st_first_valid", bus.out_valid, 1'b1);
        n0 = hcnt;
        repeat (5) tick();
        check("st_en_in_stall", hcnt - n0, 4);
        check("st_en_low", chain_en, 1'b0);
        check("st_hold_valid", bus.out_valid, 1'b1);
        check("st_hold_data", bus.out_data, 8'hA5);
        bus.out_ready = 1'b1;
        wait_done("st_done");
        b0 = (obytes.size() > 0) ? obytes[0] : 8'hEE;
        b1 = (obytes.size() > 1) ? obytes[1] : 8'hEE;
        check("st_nbytes", obytes.size(), 2);
        check("st_byte0", b0, 8'hA5);
        check("st_byte1", b1, 8'h30);
        check("st_nbits", hcnt, 12);
        check("st_chain", chain, 12'hA53);

        // Load with 3-cycle in_valid gaps
        clr_log();
        chain = '0;
        start_load = 1'b1;
        tick();
        start_load = 1'b0;
        send_byte(8'hA5, 3);
        send_byte(8'h3C, 3);
        wait_done("gap_done");
        check("gap_bits", hbits[11:0], 12'hA53);
        check("gap_nbits", hcnt, 12);
        check("gap_span", last_en - first_en + 1, 15);
        check("gap_chain", chain, 12'hA53);

        // Abort after five bits, then a clean reload
        clr_log();
        start_load = 1'b1;
        tick();
        start_load = 1'b0;
        send_byte(8'h5A, 0);
        t = 0;
        while (hcnt < 5 && t < 20) begin
            tick();
            t++;
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab_err", err, 1'b1);
        check("ab_en", chain_en, 1'b0);
        check("ab_busy", busy, 1'b0);
        check("ab_irdy", bus.in_ready, 1'b0);
        check("ab_done", done, 1'b0);
        tick();
        check("ab_en_later", chain_en, 1'b0);
        clr_log();
        start_load = 1'b1;
        tick();
        start_load = 1'b0;
        check("ab_err_clr", err, 1'b0);
        send_byte(8'hA5, 0);
        send_byte(8'h3C, 0);
        wait_done("ab_reload_done");
        check("ab_reload_bits", hbits[11:0], 12'hA53);
        check("ab_reload_chain", chain, 12'hA53);

        // Reset in the middle of a readback
        bus.out_ready = 1'b1;
        start_read = 1'b1;
        tick();
        start_read = 1'b0;
        repeat (3) tick();
        check("mr_busy", busy, 1'b1);
        #2 reset = 1'b0;
        #1;
        check_all_zero("mr");
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("mr_busy_after", busy, 1'b0);
        check("mr_done_after", done, 1'b0);
        check("mr_en_after", chain_en, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
